// File: rtl/barrido_compuerta_if.sv
// Bundle between the truth-table sweeper and its surroundings:
// gate drive/sample lines plus sweep status and results.
`timescale 1ns/1ps
interface barrido_compuerta_if #(
    parameter int CONT_W = 3
);
    logic              inicio;
    logic              salida_F;
    logic              entrada_A;
    logic              entrada_B;
    logic              ocupado;
    logic              listo;
    logic [3:0]        tabla_observada;
    logic [CONT_W-1:0] errores;
    logic              error;

    modport master (
        input  inicio,
        input  salida_F,
        output entrada_A,
        output entrada_B,
        output ocupado,
        output listo,
        output tabla_observada,
        output errores,
        output error
    );

    modport slave (
        output inicio,
        output salida_F,
        input  entrada_A,
        input  entrada_B,
        input  ocupado,
        input  listo,
        input  tabla_observada,
        input  errores,
        input  error
    );
endinterface

// File: rtl/barrido_compuerta.sv
// Walks all four {A,B} combinations into a 2-input gate, samples F
// after a settle time and compares it against an expected truth table.
`timescale 1ns/1ps
module barrido_compuerta #(
    parameter int         ESPERA         = 2,
    parameter logic [3:0] TABLA_ESPERADA = 4'b1010,
    parameter int         CONT_W         = 3
) (
    input logic                 clk,
    input logic                 rst,
    barrido_compuerta_if.master bus
);
    localparam int CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [CW-1:0] RECARGA = CW'(ESPERA - 1);
    localparam logic [CONT_W-1:0] MAXIMO = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRESENTAR,
        FIN
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [1:0]        indice_q, indice_d;
    logic [CW-1:0]     cuenta_q, cuenta_d;
    logic [3:0]        tabla_q, tabla_d;
    logic [CONT_W-1:0] errores_q, errores_d;
    logic              error_q, error_d;
    logic              listo_q, listo_d;
    logic              ocupado_q, ocupado_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= IDLE;
            indice_q  <= '0;
            cuenta_q  <= '0;
            tabla_q   <= '0;
            errores_q <= '0;
            error_q   <= 1'b0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            indice_q  <= indice_d;
            cuenta_q  <= cuenta_d;
            tabla_q   <= tabla_d;
            errores_q <= errores_d;
            error_q   <= error_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        indice_d  = indice_q;
        cuenta_d  = cuenta_q;
        tabla_d   = tabla_q;
        errores_d = errores_q;
        error_d   = error_q;
        listo_d   = listo_q;
        ocupado_d = ocupado_q;
        unique case (estado_q)
            IDLE, FIN: begin
                if (bus.inicio) begin
                    estado_d  = PRESENTAR;
                    indice_d  = '0;
                    cuenta_d  = RECARGA;
                    tabla_d   = '0;
                    errores_d = '0;
                    error_d   = 1'b0;
                    listo_d   = 1'b0;
                    ocupado_d = 1'b1;
                end
            end
            PRESENTAR: begin
                if (cuenta_q != '0) begin
                    cuenta_d = cuenta_q - 1'b1;
                end else begin
                    tabla_d[indice_q] = bus.salida_F;
                    if (bus.salida_F != TABLA_ESPERADA[indice_q]
                        && errores_q != MAXIMO) begin
                        errores_d = errores_q + 1'b1;
                    end
                    error_d  = (errores_d != '0);
                    cuenta_d = RECARGA;
                    if (indice_q == 2'd3) begin
                        // index back to 0 also parks the gate inputs low
                        estado_d  = FIN;
                        indice_d  = '0;
                        listo_d   = 1'b1;
                        ocupado_d = 1'b0;
                    end else begin
                        indice_d = indice_q + 2'd1;
                    end
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    assign bus.entrada_A       = indice_q[1];
    assign bus.entrada_B       = indice_q[0];
    assign bus.ocupado         = ocupado_q;
    assign bus.listo           = listo_q;
    assign bus.tabla_observada = tabla_q;
    assign bus.errores         = errores_q;
    assign bus.error           = error_q;
endmodule

// File: tb/tb_barrido_compuerta.sv
// Directed bench for barrido_compuerta: correct gate, stuck gates,
// ignored restart, mid-sweep reset and counter saturation.
`timescale 1ns/1ps
module tb_barrido_compuerta;
    logic clk = 1'b0;
    logic rst;
    int   modo;
    int   pasadas = 0;
    int   total = 0;
    logic [1:0] ab_esp [8] = '{2'd0, 2'd0, 2'd1, 2'd1,
                               2'd2, 2'd2, 2'd3, 2'd3};

    always #5 clk = ~clk;

    barrido_compuerta_if #(.CONT_W(3)) bus0 ();
    barrido_compuerta_if #(.CONT_W(1)) bus1 ();

    // modo 0: F=B, 1: F stuck 1, 2: F stuck 0
    assign bus0.salida_F = (modo == 0) ? bus0.entrada_B : (modo == 1);
    assign bus1.salida_F = 1'b1;

    barrido_compuerta #(
        .ESPERA(2), .TABLA_ESPERADA(4'b1010), .CONT_W(3)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    barrido_compuerta #(
        .ESPERA(2), .TABLA_ESPERADA(4'b1010), .CONT_W(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.inicio = 1'b0;
        bus1.inicio = 1'b0;
        modo = 0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({bus0.entrada_A, bus0.entrada_B, bus0.ocupado, bus0.listo,
             bus0.tabla_observada, bus0.errores, bus0.error} !== 12'd0) begin
            $display("FAIL reset0 outputs got %b%b%b%b %b %0d %b want all 0",
                     bus0.entrada_A, bus0.entrada_B, bus0.ocupado,
                     bus0.listo, bus0.tabla_observada, bus0.errores,
                     bus0.error);
        end else pasadas++;
        total++;
        if ({bus1.ocupado, bus1.listo, bus1.tabla_observada,
             bus1.errores, bus1.error} !== 8'd0) begin
            $display("FAIL reset1 outputs got %b%b %b %0d %b want all 0",
                     bus1.ocupado, bus1.listo, bus1.tabla_observada,
                     bus1.errores, bus1.error);
        end else pasadas++;
    endtask

    task automatic test_sweep_correct();
        modo = 0;
        bus0.inicio = 1'b1;
        tick();
        bus0.inicio = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            total++;
            if ({bus0.entrada_A, bus0.entrada_B} !== ab_esp[k]) begin
                $display("FAIL sweep ab after E%0d got %b%b want %b", k,
                         bus0.entrada_A, bus0.entrada_B, ab_esp[k]);
            end else pasadas++;
            total++;
            if ({bus0.ocupado, bus0.listo} !== 2'b10) begin
                $display("FAIL sweep busy after E%0d got ocupado=%b listo=%b want 1 0",
                         k, bus0.ocupado, bus0.listo);
            end else pasadas++;
        end
        tick();
        total++;
        if ({bus0.ocupado, bus0.listo, bus0.entrada_A, bus0.entrada_B}
            !== 4'b0100) begin
            $display("FAIL sweep end status got ocupado=%b listo=%b ab=%b%b want 0 1 00",
                     bus0.ocupado, bus0.listo, bus0.entrada_A, bus0.entrada_B);
        end else pasadas++;
        total++;
        if (bus0.tabla_observada !== 4'b1010 || bus0.errores !== 3'd0
            || bus0.error !== 1'b0) begin
            $display("FAIL sweep result got tabla=%b errores=%0d error=%b want 1010 0 0",
                     bus0.tabla_observada, bus0.errores, bus0.error);
        end else pasadas++;
    endtask

    task automatic test_tied_one();
        modo = 1;
        bus0.inicio = 1'b1;
        tick();
        bus0.inicio = 1'b0;
        total++;
        if (bus0.tabla_observada !== 4'b0000 || bus0.listo !== 1'b0) begin
            $display("FAIL tied1 start clear got tabla=%b listo=%b want 0000 0",
                     bus0.tabla_observada, bus0.listo);
        end else pasadas++;
        tick();
        tick();
        total++;
        if (bus0.errores !== 3'd1 || bus0.error !== 1'b1
            || bus0.tabla_observada !== 4'b0001) begin
            $display("FAIL tied1 first sample got errores=%0d error=%b tabla=%b want 1 1 0001",
                     bus0.errores, bus0.error, bus0.tabla_observada);
        end else pasadas++;
        for (int k = 3; k <= 7; k++) tick();
        total++;
        if (bus0.listo !== 1'b0) begin
            $display("FAIL tied1 early listo after E7 got %b want 0", bus0.listo);
        end else pasadas++;
        tick();
        total++;
        if (bus0.tabla_observada !== 4'b1111 || bus0.errores !== 3'd2
            || bus0.error !== 1'b1 || bus0.listo !== 1'b1) begin
            $display("FAIL tied1 result got tabla=%b errores=%0d error=%b listo=%b want 1111 2 1 1",
                     bus0.tabla_observada, bus0.errores, bus0.error, bus0.listo);
        end else pasadas++;
    endtask

    task automatic test_ignore_start();
        modo = 0;
        bus0.inicio = 1'b1;
        tick();
        bus0.inicio = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (k == 3) bus0.inicio = 1'b0;
            total++;
            if ({bus0.entrada_A, bus0.entrada_B} !== ab_esp[k]
                || bus0.listo !== 1'b0) begin
                $display("FAIL ignore after E%0d got ab=%b%b listo=%b want %b 0",
                         k, bus0.entrada_A, bus0.entrada_B, bus0.listo,
                         ab_esp[k]);
            end else pasadas++;
            if (k == 2) bus0.inicio = 1'b1;
        end
        tick();
        total++;
        if (bus0.listo !== 1'b1 || bus0.tabla_observada !== 4'b1010
            || bus0.errores !== 3'd0) begin
            $display("FAIL ignore result got listo=%b tabla=%b errores=%0d want 1 1010 0",
                     bus0.listo, bus0.tabla_observada, bus0.errores);
        end else pasadas++;
    endtask

    task automatic test_reset_mid();
        modo = 1;
        bus0.inicio = 1'b1;
        tick();
        bus0.inicio = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus0.entrada_A, bus0.entrada_B, bus0.ocupado, bus0.listo,
             bus0.tabla_observada, bus0.errores, bus0.error} !== 12'd0) begin
            $display("FAIL midreset outputs got %b%b%b%b %b %0d %b want all 0",
                     bus0.entrada_A, bus0.entrada_B, bus0.ocupado,
                     bus0.listo, bus0.tabla_observada, bus0.errores,
                     bus0.error);
        end else pasadas++;
        tick();
        tick();
        total++;
        if (bus0.ocupado !== 1'b0 || bus0.entrada_B !== 1'b0) begin
            $display("FAIL midreset idle got ocupado=%b b=%b want 0 0",
                     bus0.ocupado, bus0.entrada_B);
        end else pasadas++;
    endtask

    task automatic test_restart_from_fin();
        modo = 2;
        bus0.inicio = 1'b1;
        tick();
        bus0.inicio = 1'b0;
        total++;
        if (bus0.listo !== 1'b0 || bus0.ocupado !== 1'b1
            || bus0.tabla_observada !== 4'b0000 || bus0.errores !== 3'd0) begin
            $display("FAIL restart clear got listo=%b ocupado=%b tabla=%b errores=%0d want 0 1 0000 0",
                     bus0.listo, bus0.ocupado, bus0.tabla_observada,
                     bus0.errores);
        end else pasadas++;
        for (int k = 1; k <= 8; k++) tick();
        total++;
        if (bus0.tabla_observada !== 4'b0000 || bus0.errores !== 3'd2
            || bus0.error !== 1'b1 || bus0.listo !== 1'b1) begin
            $display("FAIL restart result got tabla=%b errores=%0d error=%b listo=%b want 0000 2 1 1",
                     bus0.tabla_observada, bus0.errores, bus0.error, bus0.listo);
        end else pasadas++;
    endtask

    task automatic test_saturate();
        bus1.inicio = 1'b1;
        tick();
        bus1.inicio = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        total++;
        if (bus1.errores !== 1'b1 || bus1.error !== 1'b1
            || bus1.tabla_observada !== 4'b1111 || bus1.listo !== 1'b1) begin
            $display("FAIL saturate got errores=%0d error=%b tabla=%b listo=%b want 1 1 1111 1",
                     bus1.errores, bus1.error, bus1.tabla_observada, bus1.listo);
        end else pasadas++;
    endtask

    initial begin
        test_reset();
        test_sweep_correct();
        test_tied_one();
        test_ignore_start();
        test_reset_mid();
        test_sweep_correct();
        test_restart_from_fin();
        test_saturate();
        $display("%0d/%0d checks passed", pasadas, total);
        $finish;
    end
endmodule
